// File: rtl/data_merge_rr_pkg.sv
// Shared constants for the two-source round-robin merge.
// Provides default data width, source index constants and a helper.
package data_merge_rr_pkg;

    localparam int   DATA_W = 32;
    localparam logic SRC0   = 1'b0;
    localparam logic SRC1   = 1'b1;

    // Source that should win the next contended grant.
    function automatic logic other_src(input logic s);
        return ~s;
    endfunction

endpackage

// File: rtl/data_merge_rr_if.sv
// Valid/ready stream bundle used between merge stages.
// Ports: data (W bits), valid, ready; master drives data/valid.
interface data_merge_rr_if #(
    parameter int W = 33
) ();

    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/data_merge_rr_skid.sv
// Two-entry elastic output stage: main register plus skid register.
// Ports: clock, reset (async low), s_in (slave stream), m_out (master stream).
module elastic_skid_reg #(
    parameter int W = 33
) (
    input  logic       clock,
    input  logic       reset,
    data_merge_rr_if.slave  s_in,
    data_merge_rr_if.master m_out
);

    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_main_v;
    logic         r_skid_v;
    logic         w_load;

    // Upstream may push only while the skid slot is free, so the
    // ready never depends on the downstream ready.
    assign s_in.ready  = ~r_skid_v;
    assign w_load      = s_in.valid & ~r_skid_v;
    assign m_out.data  = r_main;
    assign m_out.valid = r_main_v;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_main   <= '0;
            r_skid   <= '0;
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (r_skid_v) begin
            // Skid full implies main full; drain skid into main.
            if (m_out.ready) begin
                r_main   <= r_skid;
                r_skid_v <= 1'b0;
            end
        end else if (w_load) begin
            if (!r_main_v || m_out.ready) begin
                r_main   <= s_in.data;
                r_main_v <= 1'b1;
            end else begin
                r_skid   <= s_in.data;
                r_skid_v <= 1'b1;
            end
        end else if (m_out.ready) begin
            r_main_v <= 1'b0;
        end
    end

endmodule

// File: rtl/data_merge_rr.sv
// Two-source round-robin merge feeding a registered elastic output.
// Ports: clock, reset (async low), din0/din1 streams, dout/doutSrc stream.
module data_merge_rr
    import data_merge_rr_pkg::*;
#(
    parameter int dataWidth = DATA_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [dataWidth-1:0] din0,
    input  logic                 din0Valid,
    output logic                 din0Ready,
    input  logic [dataWidth-1:0] din1,
    input  logic                 din1Valid,
    output logic                 din1Ready,
    output logic [dataWidth-1:0] dout,
    output logic                 doutValid,
    input  logic                 doutReady,
    output logic                 doutSrc
);

    localparam int W = dataWidth + 1;

    logic r_prio;
    logic w_accept;
    logic w_contend;
    logic w_gnt0;
    logic w_gnt1;

    data_merge_rr_if #(.W(W)) w_in  ();
    data_merge_rr_if #(.W(W)) w_out ();

    // Readys are forced low while reset is held.
    assign w_accept  = w_in.ready & reset;
    assign w_contend = w_accept & din0Valid & din1Valid;

    assign w_gnt0 = w_accept & din0Valid
                  & (~din1Valid | (r_prio == SRC0));
    assign w_gnt1 = w_accept & din1Valid
                  & (~din0Valid | (r_prio == SRC1));

    assign din0Ready = w_gnt0;
    assign din1Ready = w_gnt1;

    assign w_in.valid = w_gnt0 | w_gnt1;
    assign w_in.data  = w_gnt1 ? {SRC1, din1} : {SRC0, din0};

    assign w_out.ready = doutReady;
    assign dout        = w_out.data[dataWidth-1:0];
    assign doutSrc     = w_out.data[dataWidth];
    assign doutValid   = w_out.valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prio <= SRC0;
        end else if (w_contend) begin
            r_prio <= other_src(w_gnt1 ? SRC1 : SRC0);
        end
    end

    elastic_skid_reg #(.W(W)) u_skid (
        .clock (clock),
        .reset (reset),
        .s_in  (w_in),
        .m_out (w_out)
    );

endmodule

// File: tb/tb_data_merge_rr.sv
// Directed self-checking bench for data_merge_rr.
// Drives both sources through stream interfaces and checks dout.
module tb_data_merge_rr;

    logic        clk;
    logic        rst_n;
    logic [31:0] dout;
    logic        doutValid;
    logic        doutReady;
    logic        doutSrc;

    int n_checks;
    int n_err;

    data_merge_rr_if #(.W(32)) s0 ();
    data_merge_rr_if #(.W(32)) s1 ();

    data_merge_rr #(.dataWidth(32)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .din0      (s0.data),
        .din0Valid (s0.valid),
        .din0Ready (s0.ready),
        .din1      (s1.data),
        .din1Valid (s1.valid),
        .din1Ready (s1.ready),
        .dout      (dout),
        .doutValid (doutValid),
        .doutReady (doutReady),
        .doutSrc   (doutSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] a0 [4];
    logic [31:0] a1 [4];
    logic [31:0] ex [8];
    logic [32:0] fq [$];
    logic [32:0] w;
    logic        g0, g1, hs;
    logic [32:0] word;
    int i0, i1;
    int sent0, sent1, got0, got1, fin, fout;

    initial begin
        n_checks = 0;
        n_err    = 0;
        a0 = '{32'd1, 32'd2, 32'd3, 32'd4};
        a1 = '{32'd11, 32'd12, 32'd13, 32'd14};
        ex = '{32'd1, 32'd11, 32'd2, 32'd12,
               32'd3, 32'd13, 32'd4, 32'd14};

        // Reset state, with both sources requesting
        rst_n     = 1'b0;
        doutReady = 1'b0;
        s0.data   = 32'h5;
        s1.data   = 32'h6;
        s0.valid  = 1'b1;
        s1.valid  = 1'b1;
        #1;
        chk("rst_rdy0", s0.ready, 0);
        chk("rst_rdy1", s1.ready, 0);
        chk("rst_vld", doutValid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_src", doutSrc, 0);
        s0.valid = 1'b0;
        s1.valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_vld", doutValid, 0);

        // Solo source 0
        s0.data   = 32'hA5;
        s0.valid  = 1'b1;
        doutReady = 1'b1;
        #1;
        chk("solo_rdy0", s0.ready, 1);
        chk("solo_rdy1", s1.ready, 0);
        tick();
        s0.valid = 1'b0;
        chk("solo_vld", doutValid, 1);
        chk("solo_dout", dout, 32'hA5);
        chk("solo_src", doutSrc, 0);
        chk("solo_prio", dut.r_prio, 0);
        tick();
        chk("solo_empty", doutValid, 0);

        // Contention, words held until accepted
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 8; c++) begin
            s0.valid = (i0 < 4);
            s1.valid = (i1 < 4);
            if (i0 < 4) s0.data = a0[i0];
            if (i1 < 4) s1.data = a1[i1];
            #1;
            g0 = s0.ready;
            g1 = s1.ready;
            chk("cont_mutex", {31'd0, g0 & g1}, 0);
            tick();
            if (g0) i0++;
            if (g1) i1++;
            chk("cont_dout", dout, ex[c]);
        end
        chk("cont_prio", dut.r_prio, 1);
        s0.valid = 1'b0;
        s1.valid = 1'b0;
        tick();
        chk("cont_empty", doutValid, 0);

        // Backpressure on source 1 stream
        doutReady = 1'b0;
        s1.data   = 32'h21;
        s1.valid  = 1'b1;
        #1;
        chk("bp_rdy_a", s1.ready, 1);
        tick();
        chk("bp_dout_a", dout, 32'h21);
        s1.data = 32'h22;
        #1;
        chk("bp_rdy_b", s1.ready, 1);
        tick();
        s1.data = 32'h23;
        #1;
        chk("bp_full_rdy", s1.ready, 0);
        chk("bp_full_rdy0", s0.ready, 0);
        tick();
        chk("bp_hold_dout", dout, 32'h21);
        chk("bp_hold_vld", doutValid, 1);
        chk("bp_hold_src", doutSrc, 1);
        chk("bp_hold_rdy", s1.ready, 0);

        // Drain and refill: skid moves to main, no grant that cycle
        doutReady = 1'b1;
        #1;
        chk("dr_no_grant", s1.ready, 0);
        tick();
        chk("dr_dout_b", dout, 32'h22);
        chk("dr_src_b", doutSrc, 1);
        chk("dr_resume", s1.ready, 1);
        tick();
        chk("dr_dout_c", dout, 32'h23);
        s1.valid = 1'b0;
        tick();
        chk("dr_empty", doutValid, 0);
        chk("dr_prio", dut.r_prio, 1);

        // Reset with main and skid full
        doutReady = 1'b0;
        s0.data   = 32'h31;
        s0.valid  = 1'b1;
        tick();
        s0.data = 32'h32;
        tick();
        chk("mr_full", s0.ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mr_vld", doutValid, 0);
        chk("mr_dout", dout, 0);
        chk("mr_prio", dut.r_prio, 0);
        chk("mr_rdy0", s0.ready, 0);
        s0.data   = 32'h41;
        s1.data   = 32'h51;
        s1.valid  = 1'b1;
        doutReady = 1'b1;
        tick();
        chk("mr_held_vld", doutValid, 0);
        rst_n = 1'b1;
        #1;
        chk("mr_rel_rdy0", s0.ready, 1);
        chk("mr_rel_rdy1", s1.ready, 0);
        tick();
        chk("mr_first", dout, 32'h41);
        chk("mr_first_src", doutSrc, 0);
        s0.valid = 1'b0;
        tick();
        chk("mr_second", dout, 32'h51);
        chk("mr_second_src", doutSrc, 1);
        s1.valid = 1'b0;
        tick();

        // Downstream FIFO of depth 4, popped every third cycle
        sent0 = 0;
        sent1 = 0;
        got0  = 0;
        got1  = 0;
        fin   = 0;
        fout  = 0;
        for (int c = 0; c < 300 && fout < 20; c++) begin
            s0.valid  = (sent0 < 10);
            s1.valid  = (sent1 < 10);
            s0.data   = 32'h100 + sent0;
            s1.data   = 32'h200 + sent1;
            doutReady = (fq.size() < 4);
            #1;
            g0   = s0.valid & s0.ready;
            g1   = s1.valid & s1.ready;
            hs   = doutValid & doutReady;
            word = {doutSrc, dout};
            @(posedge clk);
            #1;
            if (g0) sent0++;
            if (g1) sent1++;
            if (hs) begin
                fq.push_back(word);
                fin++;
            end
            if ((c % 3 == 2) && (fq.size() > 0)) begin
                w = fq.pop_front();
                fout++;
                if (w[32]) begin
                    chk("fifo_ord1", w[31:0], 32'h200 + got1);
                    got1++;
                end else begin
                    chk("fifo_ord0", w[31:0], 32'h100 + got0);
                    got0++;
                end
            end
        end
        s0.valid = 1'b0;
        s1.valid = 1'b0;
        chk("fifo_sent0", sent0, 10);
        chk("fifo_sent1", sent1, 10);
        chk("fifo_in", fin, 20);
        chk("fifo_out", fout, 20);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/data_merge_rr.md
DATA_MERGE_RR -- requirements
Module: data_merge_rr

Interface
REQ-001 SHALL have parameter dataWidth, default 32, the data word width of all data ports.
REQ-002 SHALL have port clock, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port din0, input, dataWidth, the source-0 data word.
REQ-005 SHALL have port din0Valid, input, 1, source-0 word present.
REQ-006 SHALL have port din0Ready, output, 1, source-0 word accepted this cycle when high with din0Valid.
REQ-007 SHALL have ports din1 / din1Valid / din1Ready, identical to source 0, for source 1.
REQ-008 SHALL have port dout, output, dataWidth, the merged word; it drives the downstream FIFO din.
REQ-009 SHALL have port doutValid, output, 1, dout holds a word; it drives FIFO dinValid.
REQ-010 SHALL have port doutReady, input, 1, downstream accepts; it is driven by FIFO dinReady.
REQ-011 SHALL have port doutSrc, output, 1, the index of the source that produced dout.

Function
REQ-012 SHALL transfer a word on any port only when valid and ready are both high in the same cycle.
REQ-013 SHALL contain a two-entry output stage: main register (dout, doutSrc, doutValid) and skid register (data, src, skidValid).
REQ-014 SHALL set the internal accept signal to ~skidValid; both dinXReady SHALL be 0 while skidValid=1.
REQ-015 SHALL grant, when accept=1 and exactly one source is valid, that source; din0Ready/din1Ready reflect the grant only.
REQ-016 SHALL grant, when accept=1 and both sources are valid, the source selected by the priority pointer prio (0 or 1); the other source's ready SHALL be 0.
REQ-017 SHALL toggle prio to the non-granted source after every contended grant (both valid); prio SHALL hold after uncontended grants and idle cycles.
REQ-018 SHALL never assert din0Ready and din1Ready in the same cycle.
REQ-019 SHALL let dinXReady depend combinationally on din0Valid, din1Valid and skidValid only; doutValid SHALL NOT depend combinationally on any input.
REQ-020 SHALL load a granted word into the main register when the main register is empty or doutReady=1; otherwise into the skid register, setting skidValid.
REQ-021 SHALL, when doutReady=1 and doutValid=1 and skidValid=1, move skid into main and clear skidValid in the same cycle; no new grant occurs that cycle.
REQ-022 SHALL clear doutValid when doutReady=1 and no word is loaded into main that cycle.
REQ-023 SHALL have one-cycle latency: a word granted in cycle N appears on dout in cycle N+1 when the stage was empty.
REQ-024 SHALL sustain one word per cycle while doutReady stays high.
REQ-025 SHALL hold dout, doutSrc and doutValid stable while doutValid=1 and doutReady=0.
REQ-026 SHALL preserve per-source order and never drop or duplicate a word, including at the full condition (main and skid both valid).

Reset
REQ-027 SHALL, while reset=0, force doutValid=0, skidValid=0, dout=0, doutSrc=0, prio=0, din0Ready=0, din1Ready=0, asynchronously.
REQ-028 SHALL discard any held word when reset is asserted mid-operation; the first grant after release SHALL occur no earlier than the first rising edge with reset=1.

Structure
REQ-029 SHALL take the dataWidth default and the SRC0/SRC1 index constants from the shared CGRA package.
REQ-030 SHALL place the two-entry output stage in one sub-module, elastic_skid_reg, parameterised by width (dataWidth+1); the arbiter and prio remain in data_merge_rr.

Verification
REQ-031 SHALL cover solo source: din0=0xA5 valid, din1 idle, doutReady=1 -> dout=0xA5, doutSrc=0 one cycle later, prio unchanged.
REQ-032 SHALL cover contention: both valid for 4 cycles with din0=1,2,3,4 and din1=11,12,13,14, doutReady=1 -> dout sequence 1,11,2,12.
REQ-033 SHALL cover backpressure: doutReady=0 with a stream on source 1 -> exactly two words are accepted (main+skid), then both readys=0; on release the words leave in order, one per cycle.
REQ-034 SHALL cover simultaneous drain and refill: main and skid full, doutReady=1 -> skid moves to main with no grant that cycle; grants resume the next cycle.
REQ-035 SHALL cover reset mid-stream: reset=0 asserted with main and skid full -> doutValid=0 immediately, prio=0, and the first output after release comes from source 0 under contention.
REQ-036 SHALL cover a downstream FIFO model that deasserts doutReady at its full condition -> no loss: the count of words in equals the count of words out.
